// File: rtl/div32_restoring_pkg.sv
// Shared ALU definitions for the sequential restoring divider.
// State encoding, default operand width and divide-by-zero fill value.
package div32_restoring_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient bit pattern reported on divide by zero (all ones)
    localparam logic DIV0_FILL = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div32_step.sv
// One restoring shift-subtract iteration, purely combinational.
// Holds the WIDTH+1-bit subtractor so the FSM stays register-only.
module div32_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_trial;

    assign w_trial = {i_rem, i_quo[WIDTH-1]} - {1'b0, i_b};

    always_comb begin
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32_restoring.sv
// Sequential unsigned divider, one quotient bit per clock.
// start/busy/done handshake for the ALU control FSM.
import div32_restoring_pkg::*;

module div32_restoring #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state, w_state_n;
    logic [WIDTH-1:0] r_a, w_a_n;
    logic [WIDTH-1:0] r_b, w_b_n;
    logic [WIDTH-1:0] r_rem, w_rem_n;
    logic [WIDTH-1:0] r_quo, w_quo_n;
    logic [CW-1:0]    r_cnt, w_cnt_n;
    logic             r_zero, w_zero_n;
    logic             r_busy, w_busy_n;
    logic             r_done, w_done_n;
    logic [WIDTH-1:0] r_q, w_q_n;
    logic [WIDTH-1:0] r_r, w_r_n;
    logic             r_div0, w_div0_n;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;

    div32_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_b   (r_b),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    always_comb begin
        w_state_n = r_state;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_rem_n   = r_rem;
        w_quo_n   = r_quo;
        w_cnt_n   = r_cnt;
        w_zero_n  = r_zero;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        w_q_n     = r_q;
        w_r_n     = r_r;
        w_div0_n  = r_div0;
        case (r_state)
            S_IDLE: begin
                w_busy_n = 1'b0;
                if (start) begin
                    w_a_n     = A;
                    w_b_n     = B;
                    w_rem_n   = '0;
                    w_quo_n   = A;
                    w_cnt_n   = '0;
                    w_busy_n  = 1'b1;
                    w_zero_n  = (B == '0);
                    w_state_n = (B == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                w_rem_n = w_step_rem;
                w_quo_n = w_step_quo;
                w_cnt_n = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_n = S_FIN;
                end
            end
            S_FIN: begin
                // busy stays high through the done cycle and drops in IDLE
                w_done_n  = 1'b1;
                w_state_n = S_IDLE;
                if (r_zero) begin
                    w_q_n    = {WIDTH{DIV0_FILL}};
                    w_r_n    = r_a;
                    w_div0_n = 1'b1;
                end else begin
                    w_q_n    = r_quo;
                    w_r_n    = r_rem;
                    w_div0_n = 1'b0;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_div0  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_rem   <= w_rem_n;
            r_quo   <= w_quo_n;
            r_cnt   <= w_cnt_n;
            r_zero  <= w_zero_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_q     <= w_q_n;
            r_r     <= w_r_n;
            r_div0  <= w_div0_n;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Q    = r_q;
    assign R    = r_r;
    assign div0 = r_div0;

endmodule

// File: tb/tb_div32_restoring.sv
// Randomised scoreboard bench for the restoring divider.
// Expected results come from plain / and % in the bench.
module tb_div32_restoring;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         div0;

    exp_t sb[$];
    int   checks;
    int   failures;
    logic prev_done;

    div32_restoring #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                exp_t e;
                chk("busy_during_done", {63'd0, busy}, 64'd1);
                chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending divide");
                end else begin
                    e = sb.pop_front();
                    chk("quotient", {32'd0, Q}, {32'd0, e.q});
                    chk("remainder", {32'd0, R}, {32'd0, e.r});
                    chk("div0_flag", {63'd0, div0}, {63'd0, e.z});
                    if (!e.z) begin
                        chk("invariant_qbr", {32'd0, Q} * {32'd0, e.b} + {32'd0, R},
                            {32'd0, e.a});
                        chk("invariant_r_lt_b", {63'd0, R < e.b}, 64'd1);
                    end
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        A = a;
        B = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_done: got no done expected one within 100 cycles");
        n = -1;
    endtask

    int n;
    logic [W-1:0] ra, rb;

    initial begin
        checks    = 0;
        failures  = 0;
        prev_done = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_q", {32'd0, Q}, 64'd0);
        chk("reset_r", {32'd0, R}, 64'd0);
        chk("reset_div0", {63'd0, div0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic divide and latency
        issue(100, 7);
        wait_done(n);
        chk("latency_100_7", n, 33);
        @(negedge clk);
        chk("busy_after_done", {63'd0, busy}, 64'd0);

        // 2: range corners
        issue(32'hFFFF_FFFF, 1);
        wait_done(n);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        issue(3, 10);
        wait_done(n);

        // 3: divide by zero, then a normal divide
        @(negedge clk);
        issue(5, 0);
        wait_done(n);
        chk("latency_div0", n, 1);
        issue(9, 3);
        wait_done(n);
        chk("latency_9_3", n, 33);

        // 4: start while busy ignored, back-to-back from done cycle
        @(negedge clk);
        issue(1000, 3);
        repeat (8) @(negedge clk);
        start = 1'b1;
        A = 8;
        B = 2;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        issue(8, 2);
        wait_done(n);
        chk("back_to_back_gap", n + 1, 34);

        // 5: asynchronous abort mid-divide
        @(negedge clk);
        start = 1'b1;
        A = 77;
        B = 5;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_q", {32'd0, Q}, 64'd0);
        chk("abort_r", {32'd0, R}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", {63'd0, busy}, 64'd0);
        issue(77, 5);
        wait_done(n);

        // 6: random sweep, issued back-to-back from the done cycle
        for (int i = 0; i < 1500; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = $urandom_range(1, 255);
                2: begin ra = $urandom_range(0, 1000); rb = ra + $urandom_range(1, 1000); end
                3: begin ra[W-1] = 1'b1; rb[W-1] = 1'b1; end
                4: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            issue(ra, rb);
            wait_done(n);
            chk("latency_random", n, (rb == 0) ? 1 : 33);
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("idle_busy_final", {63'd0, busy}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
